// File: rtl/demux8x1_deser.sv
// Serial-to-byte demultiplexer: steers each accepted bit into asm[bit_idx], emits completed bytes.
// Latency: byte visible the edge the 8th bit is accepted; a held byte appears on the consume edge.
// Backpressure: one byte of skid (HOLD); in_ready drops only while a completed byte waits in HOLD.
module demux8x1_deser #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flush,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] bit_idx
);

  localparam logic [2:0] IDX_START = LSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [2:0] IDX_FINAL = LSB_FIRST ? 3'd7 : 3'd0;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] asm_reg;
  logic [7:0] asm_with_bit;
  logic       accept;
  logic       consume;
  logic       slot_free;
  logic       final_bit;
  logic       load_from_collect;
  logic       load_from_hold;

  // Handshake qualifiers and the byte as it would look with the current bit steered in.
  always_comb begin
    asm_with_bit          = asm_reg;
    asm_with_bit[bit_idx] = in_bit;
    accept                = in_valid && in_ready;
    consume               = out_valid && out_ready;
    slot_free             = !out_valid || out_ready;
    final_bit             = (bit_idx == IDX_FINAL);
    // flush wins over both ways of loading the output register
    load_from_collect     = accept && final_bit && slot_free && !flush;
    load_from_hold        = (state == HOLD) && consume && !flush;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: park in HOLD when a byte completes but the output slot is still occupied.
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: begin
        if (!flush && accept && final_bit && !slot_free) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (flush || consume) begin
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Output decode: in_ready is a pure function of state, so no path from in_valid/out_ready.
  always_comb begin
    in_ready = (state == COLLECT);
  end

  // Assembly register and steering index; flush discards the partial byte and any in-flight bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_reg <= 8'h00;
      bit_idx <= IDX_START;
    end else if (flush) begin
      asm_reg <= 8'h00;
      bit_idx <= IDX_START;
    end else if (accept) begin
      asm_reg <= asm_with_bit;
      if (final_bit) begin
        bit_idx <= IDX_START;
      end else if (LSB_FIRST) begin
        bit_idx <= bit_idx + 3'd1;
      end else begin
        bit_idx <= bit_idx - 3'd1;
      end
    end
  end

  // Output register: load a fresh byte, otherwise drop valid on consume; data holds its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
    end else if (load_from_collect) begin
      out_data  <= asm_with_bit;
      out_valid <= 1'b1;
    end else if (load_from_hold) begin
      out_data  <= asm_reg;
      out_valid <= 1'b1;
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_demux8x1_deser.sv
// Bench for demux8x1_deser: LSB-first and MSB-first instances share one input stream.
// Expected bytes come from a bit-list reference model and are queued; a negedge monitor compares.
// Both instances must show identical handshake timing, only the byte bit order differs.
module tb_demux8x1_deser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready_l, out_valid_l, in_ready_m, out_valid_m;
  logic [7:0] out_data_l, out_data_m;
  logic [2:0] bit_idx_l, bit_idx_m;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  demux8x1_deser #(.LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready_l),
    .flush(flush), .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .bit_idx(bit_idx_l)
  );

  demux8x1_deser #(.LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready_m),
    .flush(flush), .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .bit_idx(bit_idx_m)
  );

  // ---------------- reference model ----------------
  // bits: bits of the byte being assembled, in arrival order.
  // exq_*: completed bytes not yet consumed; entry 0 is the one presented, entry 1 the held one.
  bit         bits[$];
  logic [7:0] exq_l[$];
  logic [7:0] exq_m[$];
  logic [7:0] last_l, last_m;
  int         pend;
  bit         acc, con;
  logic [7:0] bl, bm;
  logic [7:0] dropped;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bits.delete();
      exq_l.delete();
      exq_m.delete();
      last_l = 8'h00;
      last_m = 8'h00;
    end else begin
      pend = exq_l.size();
      acc  = in_valid && (pend < 2);
      con  = (pend > 0) && out_ready;
      if (con) begin
        last_l = exq_l.pop_front();
        last_m = exq_m.pop_front();
      end
      if (flush) begin
        if (pend == 2) begin
          dropped = exq_l.pop_back();
          dropped = exq_m.pop_back();
        end
        bits.delete();
      end else if (acc) begin
        bits.push_back(in_bit);
        if (bits.size() == 8) begin
          bl = 8'h00;
          bm = 8'h00;
          for (int i = 0; i < 8; i++) begin
            bl[i]     = bits[i];
            bm[7 - i] = bits[i];
          end
          exq_l.push_back(bl);
          exq_m.push_back(bm);
          bits.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_l", in_ready_l, int'(exq_l.size() < 2));
      chk("in_ready_m", in_ready_m, int'(exq_m.size() < 2));
      chk("out_valid_l", out_valid_l, int'(exq_l.size() > 0));
      chk("out_valid_m", out_valid_m, int'(exq_m.size() > 0));
      chk("out_data_l", out_data_l, (exq_l.size() > 0) ? exq_l[0] : last_l);
      chk("out_data_m", out_data_m, (exq_m.size() > 0) ? exq_m[0] : last_m);
      chk("bit_idx_l", bit_idx_l, bits.size());
      chk("bit_idx_m", bit_idx_m, 7 - bits.size());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one bit and hold it until the DUT accepts it (bounded).
  task automatic send_bit(input bit b);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_bit   = b;
    while (!in_ready_l && t < 64) begin
      step();
      t++;
    end
    if (t >= 64) begin
      ncmp++;
      nerr++;
      $display("FAIL send_bit_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i]);
    end
  endtask

  logic [7:0] pat;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values while rst is held
    #12;
    chk("rst_in_ready", in_ready_l, 1);
    chk("rst_out_valid", out_valid_l, 0);
    chk("rst_out_data", out_data_l, 8'h00);
    chk("rst_bit_idx_l", bit_idx_l, 0);
    chk("rst_bit_idx_m", bit_idx_m, 7);
    step();
    rst = 1'b0;
    step();

    // bits 1,0,1,0,0,1,0,1 back-to-back with a consuming sink
    out_ready = 1'b1;
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit   = pat[i];
      step();
    end
    in_valid = 1'b0;
    chk("tp1_valid", out_valid_l, 1);
    chk("tp1_byte_l", out_data_l, 8'hA5);
    chk("tp1_byte_m", out_data_m, 8'hA5);
    chk("tp1_idx_wrap", bit_idx_l, 0);
    step();

    // bits 1,1,0,0,0,0,0,0
    send_byte(8'h03);
    chk("tp2_byte_l", out_data_l, 8'h03);
    chk("tp2_byte_m", out_data_m, 8'hC0);
    step();

    // stalled sink: second byte parks in HOLD
    out_ready = 1'b0;
    send_byte(8'h3C);
    send_byte(8'h81);
    chk("tp3_hold_in_ready", in_ready_l, 0);
    chk("tp3_hold_data", out_data_l, 8'h3C);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("tp3_after_consume", out_data_l, 8'h81);
    chk("tp3_valid", out_valid_l, 1);
    chk("tp3_in_ready", in_ready_l, 1);
    out_ready = 1'b1;
    step();

    // continuous stream of four bytes
    for (int k = 0; k < 4; k++) begin
      pat = 8'h01 << k;
      for (int i = 0; i < 8; i++) begin
        chk("tp4_in_ready", in_ready_l, 1);
        in_valid = 1'b1;
        in_bit   = pat[i];
        step();
      end
      chk("tp4_byte", out_data_l, 8'h01 << k);
    end
    in_valid = 1'b0;
    step();

    // flush mid-byte together with a valid bit, then a clean 8'hFF
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("tp5_flush_idx", bit_idx_l, 0);
    send_byte(8'hFF);
    chk("tp5_byte", out_data_l, 8'hFF);
    step();

    // flush in HOLD drops the held byte, presented byte untouched
    out_ready = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("tp6_data_kept", out_data_l, 8'h11);
    chk("tp6_in_ready", in_ready_l, 1);
    out_ready = 1'b1;
    step();
    step();
    chk("tp6_drained", out_valid_l, 0);

    // async reset between edges, mid-byte, with a byte presented
    out_ready = 1'b0;
    send_byte(8'h5A);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid_l, 0);
    chk("arst_out_data", out_data_l, 8'h00);
    chk("arst_bit_idx_l", bit_idx_l, 0);
    chk("arst_bit_idx_m", bit_idx_m, 7);
    chk("arst_in_ready", in_ready_l, 1);
    step();
    rst = 1'b0;
    step();

    // randomized traffic with varying sink pressure
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom);
      out_ready = (c % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 79) == 0);
      step();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
